// File: rtl/sfu_ctrl_pkg.sv
// sfu_ctrl_pkg: shared state encoding and width helpers for the SFU sequencer
package sfu_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_RELU  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;
  localparam int N_STATES = 7;
  localparam int DEF_N_K = 9;
  localparam int DEF_N_OUT = 16;
  localparam int DEF_K_W = $clog2(DEF_N_K);
  localparam int DEF_O_W = $clog2(DEF_N_OUT);
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sfu_ctrl_wrap_counter.sv
// wrap_counter: modulo-MOD up counter (i_en, sync i_clr, active-low reset) with terminal-count flag o_tc
module wrap_counter
  import sfu_ctrl_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_tc = r_cnt == W'(MOD - 1);
  always_ff @(posedge clk)
    if (!reset || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/sfu_ctrl.sv
// sfu_ctrl: tile sequencer driving clear/accumulate/ReLU/write strobes and psum/output addresses
module sfu_ctrl
  import sfu_ctrl_pkg::*;
#(
  parameter int N_OUT = 16,
  parameter int N_K = 9,
  parameter int ADDR_W = 11,
  parameter int OADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               relu_en,
  output logic               busy,
  output logic               done,
  output logic               pmem_ren,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic               sfu_clr,
  output logic               sfu_acc,
  output logic               sfu_relu,
  output logic               omem_wen,
  output logic [OADDR_W-1:0] omem_addr
);
  localparam int W_K = cnt_w(N_K);
  localparam int W_O = cnt_w(N_OUT);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic r_relu, r_acc;
  logic [W_K-1:0] w_k;
  logic [W_O-1:0] w_o;
  logic w_k_tc, w_o_tc;
  wrap_counter #(.MOD(N_K), .W(W_K)) u_k (
    .clk(clk), .reset(reset), .i_en(r_state == S_ACC), .i_clr(r_state == S_CLR),
    .o_cnt(w_k), .o_tc(w_k_tc)
  );
  wrap_counter #(.MOD(N_OUT), .W(W_O)) u_o (
    .clk(clk), .reset(reset), .i_en(r_state == S_WRITE && !w_o_tc),
    .i_clr(r_state == S_IDLE && start), .o_cnt(w_o), .o_tc(w_o_tc)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_CLR : S_IDLE;
      S_CLR:   w_next = S_ACC;
      S_ACC:   w_next = w_k_tc ? S_DRAIN : S_ACC;
      S_DRAIN: w_next = r_relu ? S_RELU : S_WRITE;
      S_RELU:  w_next = S_WRITE;
      S_WRITE: w_next = w_o_tc ? S_DONE : S_CLR;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // r_acc delays the read enable so the accumulate strobe lines up with returning psum data
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_relu <= 1'b0;
      r_acc <= 1'b0;
    end else begin
      r_state <= w_next;
      r_acc <= r_state == S_ACC;
      r_relu <= (r_state == S_IDLE && start) ? relu_en : r_relu;
      r_addr <= (r_state == S_CLR) ? ADDR_W'(w_o)
              : (r_state == S_ACC) ? r_addr + ADDR_W'(N_OUT) : r_addr;
    end
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign pmem_ren = r_state == S_ACC;
  assign pmem_addr = r_addr;
  assign sfu_clr = r_state == S_CLR;
  assign sfu_acc = r_acc;
  assign sfu_relu = r_state == S_RELU;
  assign omem_wen = r_state == S_WRITE;
  assign omem_addr = OADDR_W'(w_o);
endmodule

// File: tb/tb_sfu_ctrl.sv
// tb_sfu_ctrl: directed vector table on a 1x3 instance plus tile-level sequences on a default instance
module tb_sfu_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;
  logic s_start = 1'b0, s_relu_en = 1'b0;
  logic s_busy, s_done, s_ren, s_clr, s_acc, s_relu, s_wen;
  logic [3:0] s_addr;
  logic [0:0] s_oaddr;
  logic d_start = 1'b0, d_relu_en = 1'b0;
  logic d_busy, d_done, d_ren, d_clr, d_acc, d_relu, d_wen;
  logic [10:0] d_addr;
  logic [3:0] d_oaddr;
  sfu_ctrl #(.N_OUT(1), .N_K(3), .ADDR_W(4), .OADDR_W(1)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .relu_en(s_relu_en),
    .busy(s_busy), .done(s_done), .pmem_ren(s_ren), .pmem_addr(s_addr),
    .sfu_clr(s_clr), .sfu_acc(s_acc), .sfu_relu(s_relu), .omem_wen(s_wen), .omem_addr(s_oaddr)
  );
  sfu_ctrl u_def (
    .clk(clk), .reset(reset), .start(d_start), .relu_en(d_relu_en),
    .busy(d_busy), .done(d_done), .pmem_ren(d_ren), .pmem_addr(d_addr),
    .sfu_clr(d_clr), .sfu_acc(d_acc), .sfu_relu(d_relu), .omem_wen(d_wen), .omem_addr(d_oaddr)
  );
  int compared = 0, mismatched = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  logic [11:0] s_vec;
  assign s_vec = {s_busy, s_done, s_ren, s_clr, s_acc, s_relu, s_wen, s_oaddr, s_ren ? s_addr : 4'd0};
  logic [21:0] d_vec;
  assign d_vec = {d_busy, d_done, d_ren, d_clr, d_acc, d_relu, d_wen, d_oaddr, d_addr};
  function automatic logic [11:0] ev(input logic b, d, ren, clr, acc, relu, wen, input logic [3:0] a);
    return {b, d, ren, clr, acc, relu, wen, 1'b0, a};
  endfunction
  typedef struct {
    logic st;
    logic rl;
    logic [11:0] ex;
  } vec_t;
  vec_t tbl[19];
  int excl_bad = 0;
  always @(negedge clk) begin
    if (!$onehot0({d_clr, d_acc, d_relu}) || !$onehot0({s_clr, s_acc, s_relu})) excl_bad <= excl_bad + 1;
    if (d_ren && (!d_busy || d_clr || d_relu || d_wen || d_done)) excl_bad <= excl_bad + 1;
    if (s_ren && (!s_busy || s_clr || s_relu || s_wen || s_done)) excl_bad <= excl_bad + 1;
  end
  int pm[144];
  int sums[16];
  int om[16];
  int rd = 0, acc_m = 0, wr_n = 0;
  int wr_q[$];
  int rd3_q[$];
  logic log_clr = 1'b0;
  always @(posedge clk) begin
    if (d_ren) rd <= pm[int'(d_addr) % 144];
    if (d_clr) acc_m <= 0;
    else if (d_acc) acc_m <= acc_m + rd;
    else if (d_relu) acc_m <= (acc_m < 0) ? 0 : acc_m;
    if (log_clr) begin
      wr_n <= 0;
      wr_q.delete();
      rd3_q.delete();
      for (int i = 0; i < 16; i++) om[i] <= -9999;
    end else begin
      if (d_wen) begin
        om[int'(d_oaddr)] <= acc_m;
        wr_n <= wr_n + 1;
        wr_q.push_back(int'(d_oaddr));
      end
      if (d_ren && wr_n == 3) rd3_q.push_back(int'(d_addr));
    end
  end
  task automatic clear_log();
    log_clr = 1'b1;
    @(posedge clk);
    #1 log_clr = 1'b0;
  endtask
  task automatic run_tile(input logic relu, input int exp_done, input bit poke, input string tag);
    int n_done = 0, first = 0, busy_bad = 0;
    clear_log();
    d_start = 1'b1;
    d_relu_en = relu;
    @(posedge clk);
    #1 d_start = 1'b0;
    for (int n = 1; n <= exp_done + 20; n++) begin
      if (poke) d_start = (n == 20 || n == 100);
      @(negedge clk);
      if (d_done) begin
        n_done++;
        if (first == 0) first = n;
      end
      if (d_busy !== (n <= exp_done)) busy_bad++;
      @(posedge clk);
      #1;
    end
    d_start = 1'b0;
    chk({tag, "_done_cycle"}, first, exp_done);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_busy_window"}, busy_bad, 0);
  endtask
  task automatic check_om(input bit relu);
    for (int o = 0; o < 16; o++) chk($sformatf("om[%0d]_relu%0d", o, relu), om[o], (relu && sums[o] < 0) ? 0 : sums[o]);
  endtask
  initial begin
    int bad, n_done;
    for (int k = 0; k < 9; k++)
      for (int o = 0; o < 16; o++) pm[k*16+o] = (o == 5) ? ((k == 0) ? 5 : -5) : o * 10 + k - 4;
    for (int o = 0; o < 16; o++) begin
      sums[o] = 0;
      for (int k = 0; k < 9; k++) sums[o] += pm[k*16+o];
    end
    tbl[0]  = '{1'b1, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, ev(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, ev(1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, ev(1, 0, 1, 0, 1, 0, 0, 1)};
    tbl[4]  = '{1'b0, 1'b0, ev(1, 0, 1, 0, 1, 0, 0, 2)};
    tbl[5]  = '{1'b0, 1'b0, ev(1, 0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1'b0, 1'b0, ev(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 1'b1, ev(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b0, ev(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, ev(1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[12] = '{1'b0, 1'b0, ev(1, 0, 1, 0, 1, 0, 0, 1)};
    tbl[13] = '{1'b0, 1'b0, ev(1, 0, 1, 0, 1, 0, 0, 2)};
    tbl[14] = '{1'b0, 1'b0, ev(1, 0, 0, 0, 1, 0, 0, 0)};
    tbl[15] = '{1'b0, 1'b0, ev(1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[16] = '{1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[17] = '{1'b0, 1'b0, ev(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0)};
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_default_outputs", d_vec, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      s_start = tbl[i].st;
      s_relu_en = tbl[i].rl;
      @(negedge clk);
      chk($sformatf("small_row%0d", i), s_vec, tbl[i].ex);
      @(posedge clk);
      #1 s_start = 1'b0;
    end
    run_tile(1'b1, 209, 1'b0, "relu");
    check_om(1'b1);
    run_tile(1'b0, 193, 1'b1, "norelu_poke");
    check_om(1'b0);
    chk("wr_count", wr_q.size(), 16);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] != i) bad++;
    chk("wr_order", bad, 0);
    chk("rd3_count", rd3_q.size(), 9);
    bad = 0;
    for (int i = 0; i < rd3_q.size(); i++) if (rd3_q[i] != 3 + 16 * i) bad++;
    chk("rd3_addrs", bad, 0);
    d_start = 1'b1;
    d_relu_en = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    repeat (48) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", d_vec, 0);
    clear_log();
    n_done = 0;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (d_done) n_done++;
    end
    @(posedge clk);
    #1;
    chk("mid_reset_no_done", n_done, 0);
    chk("mid_reset_no_write", wr_n, 0);
    run_tile(1'b1, 209, 1'b0, "after_reset");
    check_om(1'b1);
    chk("strobe_exclusive", excl_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
